// File: rtl/sm3_msg_pack.sv
// rtl/sm3_msg_pack.sv - byte-stream to big-endian word packer feeding the SM3 padding core
module sm3_msg_pack #(
  parameter  int INPT_DW  = 32,
  localparam int BYTE_NUM = INPT_DW / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_d_i,
  input  logic                byte_vld_i,
  input  logic                byte_lst_i,
  output logic                byte_rdy_o,
  output logic [INPT_DW-1:0]  msg_inpt_d_o,
  output logic [BYTE_NUM-1:0] msg_inpt_vld_byte_o,
  output logic                msg_inpt_vld_o,
  output logic                msg_inpt_lst_o,
  input  logic                msg_inpt_rdy_i,
  output logic [60:0]         msg_byte_cnt_o,
  output logic                msg_done_o
);

  localparam int PW = $clog2(BYTE_NUM);

  logic [PW-1:0]       ptr;
  logic [INPT_DW-1:0]  acc_d;
  logic [BYTE_NUM-1:0] acc_mask;
  logic                acc_lst;
  logic                acc_full;
  logic [60:0]         running;

  logic [INPT_DW-1:0]  word_d;
  logic [BYTE_NUM-1:0] word_mask;
  logic                accept;
  logic                complete;
  logic                drain;
  logic                out_free;
  logic [60:0]         running_inc;

  assign byte_rdy_o  = !acc_full;
  assign accept      = byte_vld_i && byte_rdy_o;
  assign complete    = accept && (byte_lst_i || ptr == PW'(BYTE_NUM - 1));
  assign drain       = msg_inpt_vld_o && msg_inpt_rdy_i;
  assign out_free    = !msg_inpt_vld_o || drain;
  assign running_inc = (&running) ? running : running + 61'd1;

  // Accumulator with the incoming byte merged into slot ptr; slot 0 is the MSB byte.
  always_comb begin
    word_d    = acc_d;
    word_mask = '0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (ptr == PW'(i)) word_d[INPT_DW-1-8*i -: 8] = byte_d_i;
      word_mask[BYTE_NUM-1-i] = (PW'(i) <= ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr                 <= '0;
      acc_d               <= '0;
      acc_mask            <= '0;
      acc_lst             <= 1'b0;
      acc_full            <= 1'b0;
      running             <= '0;
      msg_inpt_d_o        <= '0;
      msg_inpt_vld_byte_o <= '0;
      msg_inpt_vld_o      <= 1'b0;
      msg_inpt_lst_o      <= 1'b0;
      msg_byte_cnt_o      <= '0;
      msg_done_o          <= 1'b0;
    end else begin
      // Output register: a fresh word takes priority; a parked word only exists when no byte can arrive.
      if (complete && out_free) begin
        msg_inpt_d_o        <= word_d;
        msg_inpt_vld_byte_o <= word_mask;
        msg_inpt_lst_o      <= byte_lst_i;
        msg_inpt_vld_o      <= 1'b1;
      end else if (acc_full && drain) begin
        msg_inpt_d_o        <= acc_d;
        msg_inpt_vld_byte_o <= acc_mask;
        msg_inpt_lst_o      <= acc_lst;
        msg_inpt_vld_o      <= 1'b1;
      end else if (drain) begin
        msg_inpt_vld_o <= 1'b0;
      end

      if (complete) begin
        ptr <= '0;
        if (out_free) begin
          acc_d <= '0;
        end else begin
          acc_d    <= word_d;
          acc_mask <= word_mask;
          acc_lst  <= byte_lst_i;
          acc_full <= 1'b1;
        end
      end else if (accept) begin
        acc_d <= word_d;
        ptr   <= ptr + PW'(1);
      end else if (acc_full && drain) begin
        acc_d    <= '0;
        acc_full <= 1'b0;
      end

      msg_done_o <= 1'b0;
      if (accept) begin
        if (byte_lst_i) begin
          msg_byte_cnt_o <= running_inc;
          msg_done_o     <= 1'b1;
          running        <= '0;
        end else begin
          running <= running_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm3_msg_pack.sv
// tb/tb_sm3_msg_pack.sv - directed and randomised bench for sm3_msg_pack at 32- and 64-bit widths
module tb_sm3_msg_pack;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
    logic        l;
  } word_t;

  logic        clk;
  logic        rst;
  logic [7:0]  bd;
  logic        bvld;
  logic        blst;
  logic        sel64;
  logic        msg_rdy;
  logic        rnd_mode;

  logic        vld_in32, vld_in64, brdy32, brdy64;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [3:0]  m32;
  logic [7:0]  m64;
  logic        ov32, ov64, ol32, ol64, done32, done64;
  logic [60:0] cnt32, cnt64;
  logic        brdy;

  int errors = 0;
  int checks = 0;

  word_t   exp32[$];
  word_t   exp64[$];
  longint  c32[$];
  longint  c64[$];
  logic [7:0] msg_q[$];
  word_t   ew32, ew64;
  longint  ec32, ec64;

  assign vld_in32 = bvld && !sel64;
  assign vld_in64 = bvld && sel64;
  assign brdy     = sel64 ? brdy64 : brdy32;

  sm3_msg_pack #(.INPT_DW(32)) dut32 (
    .clk(clk), .rst(rst), .byte_d_i(bd), .byte_vld_i(vld_in32), .byte_lst_i(blst),
    .byte_rdy_o(brdy32), .msg_inpt_d_o(d32), .msg_inpt_vld_byte_o(m32),
    .msg_inpt_vld_o(ov32), .msg_inpt_lst_o(ol32), .msg_inpt_rdy_i(msg_rdy),
    .msg_byte_cnt_o(cnt32), .msg_done_o(done32)
  );

  sm3_msg_pack #(.INPT_DW(64)) dut64 (
    .clk(clk), .rst(rst), .byte_d_i(bd), .byte_vld_i(vld_in64), .byte_lst_i(blst),
    .byte_rdy_o(brdy64), .msg_inpt_d_o(d64), .msg_inpt_vld_byte_o(m64),
    .msg_inpt_vld_o(ov64), .msg_inpt_lst_o(ol64), .msg_inpt_rdy_i(msg_rdy),
    .msg_byte_cnt_o(cnt64), .msg_done_o(done64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) msg_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bvld = 1'b1;
    bd   = d;
    blst = l;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = brdy;
      tick();
      n++;
    end
    check("byte_accept", acc, 1'b1);
    bvld = 1'b0;
    blst = 1'b0;
  endtask

  task automatic push32(input logic [31:0] d, input logic [3:0] m, input logic l);
    word_t e;
    e.d = {32'h0, d};
    e.m = {4'h0, m};
    e.l = l;
    exp32.push_back(e);
  endtask

  task automatic push64(input logic [63:0] d, input logic [7:0] m, input logic l);
    word_t e;
    e.d = d;
    e.m = m;
    e.l = l;
    exp64.push_back(e);
  endtask

  // Reference packer: builds the expected word sequence of msg_q for a given lane count.
  task automatic model_msg(input bit is64);
    int          bn, slot, n;
    logic [63:0] w;
    logic [7:0]  m;
    word_t       e;
    bn   = is64 ? 8 : 4;
    n    = msg_q.size();
    w    = '0;
    m    = '0;
    slot = 0;
    for (int i = 0; i < n; i++) begin
      w = w | (64'(msg_q[i]) << (8 * (bn - 1 - slot)));
      m = m | (8'(1) << (bn - 1 - slot));
      slot++;
      if (slot == bn || i == n - 1) begin
        e.d = w;
        e.m = m;
        e.l = (i == n - 1);
        if (is64) exp64.push_back(e);
        else exp32.push_back(e);
        w    = '0;
        m    = '0;
        slot = 0;
      end
    end
    if (is64) c64.push_back(longint'(n));
    else c32.push_back(longint'(n));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp32.size() + exp64.size() + c32.size() + c64.size()) != 0 && n < 5000) begin
      tick();
      n++;
    end
    check("drain_left", 64'(exp32.size() + exp64.size() + c32.size() + c64.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && ov32 && msg_rdy) begin
      if (exp32.size() == 0) check("w32_expected_pending", 1'b0, 1'b1);
      else begin
        ew32 = exp32.pop_front();
        check("w32_d", {32'h0, d32}, ew32.d);
        check("w32_mask", {60'h0, m32}, ew32.m);
        check("w32_lst", ol32, ew32.l);
      end
    end
    if (!rst && done32) begin
      if (c32.size() == 0) check("c32_expected_pending", 1'b0, 1'b1);
      else begin
        ec32 = c32.pop_front();
        check("c32_cnt", 64'(cnt32), ec32);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov64 && msg_rdy) begin
      if (exp64.size() == 0) check("w64_expected_pending", 1'b0, 1'b1);
      else begin
        ew64 = exp64.pop_front();
        check("w64_d", d64, ew64.d);
        check("w64_mask", {56'h0, m64}, ew64.m);
        check("w64_lst", ol64, ew64.l);
      end
    end
    if (!rst && done64) begin
      if (c64.size() == 0) check("c64_expected_pending", 1'b0, 1'b1);
      else begin
        ec64 = c64.pop_front();
        check("c64_cnt", 64'(cnt64), ec64);
      end
    end
  end

  initial begin
    int len;
    rst      = 1'b1;
    bd       = '0;
    bvld     = 1'b0;
    blst     = 1'b0;
    sel64    = 1'b0;
    msg_rdy  = 1'b0;
    rnd_mode = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld32", ov32, 1'b0);
    check("rst_d32", {32'h0, d32}, 64'h0);
    check("rst_brdy32", brdy32, 1'b1);
    check("rst_cnt32", 64'(cnt32), 64'h0);
    check("rst_done32", done32, 1'b0);
    check("rst_vld64", ov64, 1'b0);
    check("rst_brdy64", brdy64, 1'b1);
    tick();

    // 10 bytes 01..0A, ready held high
    msg_rdy = 1'b1;
    push32(32'h01020304, 4'hF, 1'b0);
    push32(32'h05060708, 4'hF, 1'b0);
    push32(32'h090A0000, 4'hC, 1'b1);
    c32.push_back(10);
    for (int i = 1; i <= 10; i++) send_byte(8'(i), i == 10);
    wait_drain();

    // exact-width last word, then a one-byte message back to back
    push32(32'hAABBCCDD, 4'hF, 1'b1);
    c32.push_back(4);
    push32(32'h55000000, 4'h8, 1'b1);
    c32.push_back(1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_drain();

    // back-pressure: first word held, second parks, byte_rdy drops
    msg_rdy = 1'b0;
    push32(32'h01020304, 4'hF, 1'b0);
    push32(32'h05060708, 4'hF, 1'b0);
    push32(32'h090A0B0C, 4'hF, 1'b1);
    c32.push_back(12);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_brdy", brdy32, 1'b0);
      check("hold_vld", ov32, 1'b1);
      check("hold_d", {32'h0, d32}, 64'h01020304);
      check("hold_mask", {60'h0, m32}, 64'hF);
      check("hold_lst", ol32, 1'b0);
      tick();
    end
    msg_rdy = 1'b1;
    for (int i = 9; i <= 12; i++) send_byte(8'(i), i == 12);
    wait_drain();

    // 64-bit lanes
    sel64 = 1'b1;
    push64(64'h0102030000000000, 8'hE0, 1'b1);
    c64.push_back(3);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    push64(64'h1011121314151617, 8'hFF, 1'b0);
    push64(64'h18191A1B1C1D1E1F, 8'hFF, 1'b1);
    c64.push_back(16);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), i == 15);
    wait_drain();

    // reset mid-message with the output stalled
    sel64   = 1'b0;
    msg_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_vld", ov32, 1'b0);
    check("abort_lst", ol32, 1'b0);
    check("abort_cnt", 64'(cnt32), 64'h0);
    check("abort_brdy", brdy32, 1'b1);
    tick();
    msg_rdy = 1'b1;
    push32(32'h0E0F0000, 4'hC, 1'b1);
    c32.push_back(2);
    send_byte(8'h0E, 1'b0);
    send_byte(8'h0F, 1'b1);
    wait_drain();

    // random lengths and random ready on both widths
    rnd_mode = 1'b1;
    for (int mi = 0; mi < 200; mi++) begin
      sel64 = 1'($urandom_range(0, 1));
      len   = $urandom_range(1, 200);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      model_msg(sel64);
      for (int i = 0; i < len; i++) begin
        send_byte(msg_q[i], i == len - 1);
        if ($urandom_range(0, 7) == 0) tick();
      end
    end
    rnd_mode = 1'b0;
    msg_rdy  = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
